// File: rtl/cellram_pkg.sv
// Shared types and constants for the CellularRAM async responder.
package cellram_pkg;

    // Responder protocol state
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_ACC    = 3'd1,
        RD_DRV    = 3'd2,
        WR_ACT    = 3'd3,
        WR_COMMIT = 3'd4
    } cr_state_t;

    // Configuration-register select, taken from addr[19:18] when CRE is high
    localparam logic [1:0] SEL_RCR  = 2'b00;
    localparam logic [1:0] SEL_DIDR = 2'b01;
    localparam logic [1:0] SEL_BCR  = 2'b10;

    // Configuration register reset values
    localparam logic [15:0] BCR_RST = 16'h9D1F;
    localparam logic [15:0] RCR_RST = 16'h0010;

    // Saturation point of the access cycle counter
    localparam logic [3:0] CNT_MAX = 4'd15;

endpackage

// File: rtl/cellram_resp_mem.sv
// Single-port word array with per-byte write enables and a registered,
// read-first data output. The array itself is never reset.
module cellram_resp_mem
    import cellram_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [1:0]            wr_be,
    input  logic [15:0]           wr_data,
    output logic [15:0]           rd_data
);

    logic [15:0] mem_r [0:(2**DEPTH_LOG2)-1];
    logic [15:0] rd_data_r;

    // Byte-lane writes into the array
    always_ff @(posedge clk) begin
        if (wr_be[0]) begin
            mem_r[addr][7:0] <= wr_data[7:0];
        end
        if (wr_be[1]) begin
            mem_r[addr][15:8] <= wr_data[15:8];
        end
    end

    // Registered read of the addressed word (old data on a same-cycle write)
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_r <= 16'h0000;
        end else begin
            rd_data_r <= mem_r[addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/cellram_async_responder.sv
// Device-side responder for the asynchronous CellularRAM pin interface.
// Decodes the control pins, serves array and configuration-register
// accesses, and pulses viol on protocol violations.
module cellram_async_responder
    import cellram_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 10,
    parameter int          READ_LAT   = 4,
    parameter int          WRITE_MIN  = 3,
    parameter logic [15:0] DIDR_VAL   = 16'h0443
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:1] ram_addr,
    input  logic        ram_adv_n,
    input  logic        ram_cre,
    input  logic        ram_ce_n,
    input  logic        ram_oe_n,
    input  logic        ram_we_n,
    input  logic        ram_lb_n,
    input  logic        ram_ub_n,
    input  logic [15:0] ram_dq_in,
    output logic [15:0] ram_dq_out,
    output logic [1:0]  ram_dq_oe,
    output logic        ram_wait,
    output logic [15:0] bcr,
    output logic [15:0] rcr,
    output logic        viol
);

    localparam logic [3:0] READ_LAT_C  = 4'(READ_LAT);
    localparam logic [3:0] WRITE_MIN_C = 4'(WRITE_MIN);

    cr_state_t state_r, state_s;
    logic [3:0]  cnt_r, cnt_s;
    logic [23:1] addr_r;
    logic        cre_r;
    logic [15:0] wdata_r, wdata_s;
    logic        lb_n_r, lb_n_s, ub_n_r, ub_n_s;
    logic [15:0] dq_out_r, dq_out_s;
    logic [1:0]  dq_oe_r, dq_oe_s;
    logic        viol_r, viol_s;
    logic [15:0] bcr_r, bcr_s, rcr_r, rcr_s;
    logic        oe_we_r, oe_we_s;
    logic        addr_chg_s;
    logic        release_s;
    logic [DEPTH_LOG2-1:0] mem_addr_s;
    logic [1:0]  mem_be_s;
    logic [15:0] mem_rd_s;

    // Capture address and CRE whenever ADV# is low
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r <= 23'h000000;
            cre_r  <= 1'b0;
        end else if (!ram_adv_n) begin
            addr_r <= ram_addr;
            cre_r  <= ram_cre;
        end else begin
            addr_r <= addr_r;
            cre_r  <= cre_r;
        end
    end

    // A new address (or CRE) presented while ADV# is low restarts a read
    assign addr_chg_s = ~ram_adv_n & ((ram_addr != addr_r) | (ram_cre != cre_r));
    assign release_s  = ram_ce_n | ram_we_n;
    assign oe_we_s    = ~ram_ce_n & ~ram_we_n & ~ram_oe_n;

    // Array address: latched address for commits, otherwise the address that
    // is being latched this cycle so the registered read tracks it
    always_comb begin
        mem_addr_s = addr_r[DEPTH_LOG2:1];
        if (state_r == WR_COMMIT) begin
            mem_addr_s = addr_r[DEPTH_LOG2:1];
        end else if (!ram_adv_n) begin
            mem_addr_s = ram_addr[DEPTH_LOG2:1];
        end else begin
            mem_addr_s = addr_r[DEPTH_LOG2:1];
        end
    end

    // Array byte enables: only during a non-config commit, never under reset
    always_comb begin
        mem_be_s = 2'b00;
        if ((state_r == WR_COMMIT) && !cre_r && !rst) begin
            mem_be_s = ~{ub_n_r, lb_n_r};
        end else begin
            mem_be_s = 2'b00;
        end
    end

    cellram_resp_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .addr    (mem_addr_s),
        .wr_be   (mem_be_s),
        .wr_data (wdata_r),
        .rd_data (mem_rd_s)
    );

    // Next-state, counter, data capture and output decode
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        wdata_s  = wdata_r;
        lb_n_s   = lb_n_r;
        ub_n_s   = ub_n_r;
        dq_out_s = dq_out_r;
        dq_oe_s  = 2'b00;
        viol_s   = 1'b0;
        bcr_s    = bcr_r;
        rcr_s    = rcr_r;
        case (state_r)
            IDLE: begin
                if (!ram_ce_n && ram_we_n) begin
                    state_s = RD_ACC;
                    cnt_s   = 4'd1;
                end else if (!ram_ce_n && !ram_we_n) begin
                    state_s = WR_ACT;
                    cnt_s   = 4'd1;
                    wdata_s = ram_dq_in;
                    lb_n_s  = ram_lb_n;
                    ub_n_s  = ram_ub_n;
                end else begin
                    state_s = IDLE;
                end
            end
            RD_ACC: begin
                if (ram_ce_n) begin
                    state_s = IDLE;
                end else if (!ram_we_n) begin
                    state_s = WR_ACT;
                    cnt_s   = 4'd1;
                    wdata_s = ram_dq_in;
                    lb_n_s  = ram_lb_n;
                    ub_n_s  = ram_ub_n;
                end else if (addr_chg_s) begin
                    cnt_s = 4'd1;
                end else if (cnt_r == READ_LAT_C) begin
                    state_s = RD_DRV;
                    if (!cre_r) begin
                        dq_out_s = mem_rd_s;
                    end else begin
                        case (addr_r[19:18])
                            SEL_BCR:  dq_out_s = bcr_r;
                            SEL_RCR:  dq_out_s = rcr_r;
                            SEL_DIDR: dq_out_s = DIDR_VAL;
                            default: begin
                                dq_out_s = 16'h0000;
                                viol_s   = 1'b1;
                            end
                        endcase
                    end
                end else begin
                    cnt_s = cnt_r + 4'd1;
                end
            end
            RD_DRV: begin
                if (ram_ce_n) begin
                    state_s = IDLE;
                end else if (addr_chg_s) begin
                    state_s = RD_ACC;
                    cnt_s   = 4'd1;
                end else if (!ram_we_n) begin
                    state_s = WR_ACT;
                    cnt_s   = 4'd1;
                    wdata_s = ram_dq_in;
                    lb_n_s  = ram_lb_n;
                    ub_n_s  = ram_ub_n;
                end else begin
                    dq_oe_s = {~ram_oe_n & ~ram_ub_n, ~ram_oe_n & ~ram_lb_n};
                end
            end
            WR_ACT: begin
                if (release_s) begin
                    if (cnt_r >= WRITE_MIN_C) begin
                        state_s = WR_COMMIT;
                    end else begin
                        state_s = IDLE;
                        viol_s  = 1'b1;
                    end
                end else begin
                    wdata_s = ram_dq_in;
                    lb_n_s  = ram_lb_n;
                    ub_n_s  = ram_ub_n;
                    if (cnt_r == CNT_MAX) begin
                        cnt_s = cnt_r;
                    end else begin
                        cnt_s = cnt_r + 4'd1;
                    end
                end
            end
            WR_COMMIT: begin
                state_s = IDLE;
                if (cre_r) begin
                    case (addr_r[19:18])
                        SEL_BCR: bcr_s  = wdata_r;
                        SEL_RCR: rcr_s  = wdata_r;
                        default: viol_s = 1'b1;
                    endcase
                end else begin
                    viol_s = 1'b0;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        // OE# asserted during an active write: flag once at its onset
        viol_s = viol_s | (oe_we_s & ~oe_we_r);
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            cnt_r    <= 4'd0;
            wdata_r  <= 16'h0000;
            lb_n_r   <= 1'b1;
            ub_n_r   <= 1'b1;
            dq_out_r <= 16'h0000;
            dq_oe_r  <= 2'b00;
            viol_r   <= 1'b0;
            bcr_r    <= BCR_RST;
            rcr_r    <= RCR_RST;
            oe_we_r  <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            wdata_r  <= wdata_s;
            lb_n_r   <= lb_n_s;
            ub_n_r   <= ub_n_s;
            dq_out_r <= dq_out_s;
            dq_oe_r  <= dq_oe_s;
            viol_r   <= viol_s;
            bcr_r    <= bcr_s;
            rcr_r    <= rcr_s;
            oe_we_r  <= oe_we_s;
        end
    end

    assign ram_dq_out = dq_out_r;
    assign ram_dq_oe  = dq_oe_r;
    assign ram_wait   = 1'b0;
    assign bcr        = bcr_r;
    assign rcr        = rcr_r;
    assign viol       = viol_r;

endmodule

// File: tb/tb_cellram_async_responder.sv
// Directed bench for cellram_async_responder (default parameters).
module tb_cellram_async_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:1] ram_addr;
    logic        ram_adv_n, ram_cre, ram_ce_n, ram_oe_n, ram_we_n, ram_lb_n, ram_ub_n;
    logic [15:0] ram_dq_in;
    logic [15:0] ram_dq_out;
    logic [1:0]  ram_dq_oe;
    logic        ram_wait;
    logic [15:0] bcr, rcr;
    logic        viol;

    int n_assert = 0;
    int n_fail   = 0;
    int viol_cnt = 0;
    int viol_base;

    logic [15:0] rd_d;
    logic [1:0]  rd_oe;
    logic [23:1] a_cfg;

    cellram_async_responder dut (
        .clk        (clk),
        .rst        (rst),
        .ram_addr   (ram_addr),
        .ram_adv_n  (ram_adv_n),
        .ram_cre    (ram_cre),
        .ram_ce_n   (ram_ce_n),
        .ram_oe_n   (ram_oe_n),
        .ram_we_n   (ram_we_n),
        .ram_lb_n   (ram_lb_n),
        .ram_ub_n   (ram_ub_n),
        .ram_dq_in  (ram_dq_in),
        .ram_dq_out (ram_dq_out),
        .ram_dq_oe  (ram_dq_oe),
        .ram_wait   (ram_wait),
        .bcr        (bcr),
        .rcr        (rcr),
        .viol       (viol)
    );

    always #5 clk = ~clk;

    // Count cycles with viol high, sampled mid-cycle
    always @(negedge clk) begin
        if (viol) viol_cnt <= viol_cnt + 1;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Write: n_low cycles of CE#/WE# low, CE# released first, then commit
    task automatic wr(input logic [23:1] a, input logic c, input logic [15:0] d,
                      input logic lb, input logic ub, input int n_low);
        ram_addr = a; ram_cre = c; ram_adv_n = 1'b0; ram_dq_in = d;
        ram_lb_n = lb; ram_ub_n = ub; ram_oe_n = 1'b1;
        ram_ce_n = 1'b0; ram_we_n = 1'b0;
        cyc(n_low);
        ram_ce_n = 1'b1;
        cyc(1);
        ram_we_n = 1'b1; ram_adv_n = 1'b1; ram_dq_in = 16'h0000;
        cyc(1);
    endtask

    // Read: hold the access for six edges, sample data and byte enables
    task automatic rd(input logic [23:1] a, input logic c, input logic lb, input logic ub,
                      output logic [15:0] d, output logic [1:0] oe);
        ram_addr = a; ram_cre = c; ram_adv_n = 1'b0;
        ram_lb_n = lb; ram_ub_n = ub;
        ram_ce_n = 1'b0; ram_we_n = 1'b1; ram_oe_n = 1'b0;
        cyc(6);
        d  = ram_dq_out;
        oe = ram_dq_oe;
        ram_ce_n = 1'b1; ram_oe_n = 1'b1; ram_adv_n = 1'b1;
        cyc(1);
    endtask

    initial begin
        rst = 1'b1; ram_addr = 23'h000000; ram_adv_n = 1'b1; ram_cre = 1'b0;
        ram_ce_n = 1'b1; ram_oe_n = 1'b1; ram_we_n = 1'b1;
        ram_lb_n = 1'b0; ram_ub_n = 1'b0; ram_dq_in = 16'h0000;
        cyc(2);
        rst = 1'b0;
        cyc(1);

        // Reset state
        chk("rst_dq_oe", 16'(ram_dq_oe), 16'h0000);
        chk("rst_dq_out", ram_dq_out, 16'h0000);
        chk("rst_viol", 16'(viol), 16'h0000);
        chk("rst_wait", 16'(ram_wait), 16'h0000);
        chk("rst_bcr", bcr, 16'h9D1F);
        chk("rst_rcr", rcr, 16'h0010);

        // Read latency: oe low after edge 4, both lanes driven after edge 5
        ram_addr = 23'h000010; ram_adv_n = 1'b0; ram_cre = 1'b0;
        ram_ce_n = 1'b0; ram_oe_n = 1'b0; ram_we_n = 1'b1;
        cyc(5);
        chk("lat_oe_edge4", 16'(ram_dq_oe), 16'h0000);
        cyc(1);
        chk("lat_oe_edge5", 16'(ram_dq_oe), 16'h0003);
        ram_ce_n = 1'b1; ram_oe_n = 1'b1; ram_adv_n = 1'b1;
        cyc(1);
        chk("ce_release_oe", 16'(ram_dq_oe), 16'h0000);
        chk("bcr_after_read", bcr, 16'h9D1F);

        // Full write and readback
        viol_base = viol_cnt;
        wr(23'h000020, 1'b0, 16'hBEEF, 1'b0, 1'b0, 4);
        rd(23'h000020, 1'b0, 1'b0, 1'b0, rd_d, rd_oe);
        chk("rd_beef", rd_d, 16'hBEEF);
        chk("rd_beef_oe", 16'(rd_oe), 16'h0003);
        chk("no_viol_wr", 16'(viol_cnt - viol_base), 16'h0000);

        // Byte-lane writes
        wr(23'h000020, 1'b0, 16'h1234, 1'b0, 1'b1, 4);
        rd(23'h000020, 1'b0, 1'b0, 1'b0, rd_d, rd_oe);
        chk("rd_lower_lane", rd_d, 16'hBE34);
        wr(23'h000020, 1'b0, 16'h5678, 1'b1, 1'b0, 4);
        rd(23'h000020, 1'b0, 1'b0, 1'b1, rd_d, rd_oe);
        chk("rd_upper_lane", rd_d, 16'h5634);
        chk("rd_oe_lb_only", 16'(rd_oe), 16'h0001);

        // Configuration registers
        a_cfg = 23'h000000; a_cfg[19:18] = 2'b10;
        wr(a_cfg, 1'b1, 16'h8010, 1'b1, 1'b1, 4);
        chk("bcr_write", bcr, 16'h8010);
        rd(a_cfg, 1'b1, 1'b0, 1'b0, rd_d, rd_oe);
        chk("bcr_read", rd_d, 16'h8010);
        a_cfg[19:18] = 2'b00;
        wr(a_cfg, 1'b1, 16'h0012, 1'b0, 1'b0, 3);
        chk("rcr_write", rcr, 16'h0012);
        a_cfg[19:18] = 2'b01;
        rd(a_cfg, 1'b1, 1'b0, 1'b0, rd_d, rd_oe);
        chk("didr_read", rd_d, 16'h0443);
        viol_base = viol_cnt;
        a_cfg[19:18] = 2'b11;
        rd(a_cfg, 1'b1, 1'b0, 1'b0, rd_d, rd_oe);
        chk("sel11_read", rd_d, 16'h0000);
        chk("sel11_viol", 16'(viol_cnt - viol_base), 16'h0001);
        chk("no_viol_cfg_wr", 16'(viol_base), 16'h0000);

        // Short write: two cycles low is below the minimum
        viol_base = viol_cnt;
        ram_addr = 23'h000020; ram_cre = 1'b0; ram_adv_n = 1'b0;
        ram_dq_in = 16'h0000; ram_lb_n = 1'b0; ram_ub_n = 1'b0;
        ram_ce_n = 1'b0; ram_we_n = 1'b0;
        cyc(2);
        ram_ce_n = 1'b1;
        cyc(1);
        chk("short_viol_hi", 16'(viol), 16'h0001);
        ram_we_n = 1'b1; ram_adv_n = 1'b1;
        cyc(1);
        chk("short_viol_lo", 16'(viol), 16'h0000);
        rd(23'h000020, 1'b0, 1'b0, 1'b0, rd_d, rd_oe);
        chk("short_no_write", rd_d, 16'h5634);
        chk("short_viol_once", 16'(viol_cnt - viol_base), 16'h0001);

        // Exactly WRITE_MIN cycles low commits
        wr(23'h000030, 1'b0, 16'hA5A5, 1'b0, 1'b0, 3);
        rd(23'h000030, 1'b0, 1'b0, 1'b0, rd_d, rd_oe);
        chk("min_write", rd_d, 16'hA5A5);

        // OE# low during a write: single viol pulse, write still lands
        viol_base = viol_cnt;
        ram_addr = 23'h000040; ram_cre = 1'b0; ram_adv_n = 1'b0;
        ram_dq_in = 16'h0F0F; ram_lb_n = 1'b0; ram_ub_n = 1'b0;
        ram_ce_n = 1'b0; ram_we_n = 1'b0; ram_oe_n = 1'b0;
        cyc(1);
        chk("oewe_viol_hi", 16'(viol), 16'h0001);
        cyc(1);
        chk("oewe_viol_lo", 16'(viol), 16'h0000);
        chk("oewe_dq_oe", 16'(ram_dq_oe), 16'h0000);
        cyc(2);
        ram_ce_n = 1'b1; ram_oe_n = 1'b1;
        cyc(1);
        ram_we_n = 1'b1; ram_adv_n = 1'b1;
        cyc(1);
        chk("oewe_viol_once", 16'(viol_cnt - viol_base), 16'h0001);
        rd(23'h000040, 1'b0, 1'b0, 1'b0, rd_d, rd_oe);
        chk("oewe_write", rd_d, 16'h0F0F);

        // Reset in the middle of a write aborts it
        ram_addr = 23'h000020; ram_cre = 1'b0; ram_adv_n = 1'b0;
        ram_dq_in = 16'hDEAD; ram_ce_n = 1'b0; ram_we_n = 1'b0;
        cyc(2);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0; ram_ce_n = 1'b1; ram_we_n = 1'b1; ram_adv_n = 1'b1;
        chk("rstwr_dq_oe", 16'(ram_dq_oe), 16'h0000);
        chk("rstwr_bcr", bcr, 16'h9D1F);
        chk("rstwr_rcr", rcr, 16'h0010);
        cyc(2);
        rd(23'h000020, 1'b0, 1'b0, 1'b0, rd_d, rd_oe);
        chk("rstwr_no_write", rd_d, 16'h5634);

        // Reset while driving read data drops oe on the next edge
        ram_addr = 23'h000030; ram_cre = 1'b0; ram_adv_n = 1'b0;
        ram_ce_n = 1'b0; ram_we_n = 1'b1; ram_oe_n = 1'b0;
        cyc(6);
        chk("rstrd_oe_before", 16'(ram_dq_oe), 16'h0003);
        chk("rstrd_data", ram_dq_out, 16'hA5A5);
        rst = 1'b1;
        cyc(1);
        chk("rstrd_oe_after", 16'(ram_dq_oe), 16'h0000);
        chk("rstrd_dq_out", ram_dq_out, 16'h0000);
        rst = 1'b0; ram_ce_n = 1'b1; ram_oe_n = 1'b1; ram_adv_n = 1'b1;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
